// File: rtl/wb_bus_monitor.sv
// Passive Wishbone classic-cycle protocol monitor: watches one slave port and
// reports handshake violations via sticky flags, saturating counters and first-error capture.
module wb_bus_monitor #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16,
  parameter int CW      = 16
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            en_i,
  input  logic            clr_i,
  input  logic            wb_cyc_i,
  input  logic            wb_stb_i,
  input  logic            wb_we_i,
  input  logic [AW-1:0]   wb_adr_i,
  input  logic [DW/8-1:0] wb_sel_i,
  input  logic [DW-1:0]   wb_dat_i,
  input  logic            wb_ack_i,
  output logic            busy_o,
  output logic            err_pulse_o,
  output logic [4:0]      err_flags_o,
  output logic [2:0]      first_err_code_o,
  output logic [AW-1:0]   first_err_adr_o,
  output logic [CW-1:0]   err_cnt_o,
  output logic [CW-1:0]   xfer_cnt_o
);

  localparam int SW = DW / 8;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_TMO
  } state_t;

  state_t         r_state;
  state_t         w_next_state;

  logic [TW-1:0]  r_wait_cnt;
  logic [TW-1:0]  w_wait_cnt_nxt;
  logic [AW-1:0]  r_adr;
  logic           r_we;
  logic [SW-1:0]  r_sel;
  logic [DW-1:0]  r_dat;

  logic           r_err_pulse;
  logic [4:0]     r_err_flags;
  logic [2:0]     r_first_code;
  logic [AW-1:0]  r_first_adr;
  logic [CW-1:0]  r_err_cnt;
  logic [CW-1:0]  r_xfer_cnt;

  logic           w_req;
  logic           w_unstable;
  logic           w_wait_last;
  logic [4:0]     w_err;
  logic           w_xfer;
  logic           w_capture;

  assign w_req      = wb_cyc_i & wb_stb_i;
  // Data only matters while the held request is a write.
  assign w_unstable = (wb_adr_i != r_adr) | (wb_we_i != r_we) | (wb_sel_i != r_sel) |
                      (r_we & (wb_dat_i != r_dat));
  // The first request edge loads wait_cnt=1, so edge N of a stalled request sees N-1.
  assign w_wait_last = (r_wait_cnt == TW'(TIMEOUT - 1));

  function automatic logic [2:0] lowest_code(input logic [4:0] errs);
    logic [2:0] code;
    code = '0;
    for (int k = 4; k >= 0; k--) begin
      if (errs[k]) code = 3'(k + 1);
    end
    return code;
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of process ordering.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) r_state <= S_IDLE;
    else          r_state <= w_next_state;
  end

  // NOTE: each combinational output is given a default before the case so no
  // path leaves it unassigned and a latch is never inferred.
  always_comb begin
    w_next_state = r_state;
    if (!en_i) begin
      w_next_state = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (w_req && !wb_ack_i) w_next_state = S_WAIT;
        S_WAIT: begin
          if (!w_req || wb_ack_i) w_next_state = S_IDLE;
          else if (w_wait_last)   w_next_state = S_TMO;
        end
        S_TMO:  if (!w_req || wb_ack_i) w_next_state = S_IDLE;
        default: w_next_state = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_err          = '0;
    w_xfer         = 1'b0;
    w_capture      = 1'b0;
    w_wait_cnt_nxt = r_wait_cnt;
    if (en_i) begin
      w_err[0] = wb_stb_i & ~wb_cyc_i;
      w_err[1] = wb_ack_i & ~w_req;
      case (r_state)
        S_IDLE: begin
          if (w_req && wb_ack_i) begin
            w_xfer = 1'b1;
          end else if (w_req) begin
            w_capture      = 1'b1;
            w_wait_cnt_nxt = TW'(1);
          end
        end
        S_WAIT: begin
          // Recapturing every sample makes each distinct change flag once.
          w_err[2]  = w_unstable;
          w_capture = 1'b1;
          if (!w_req)           w_err[4] = 1'b1;
          else if (wb_ack_i)    w_xfer   = 1'b1;
          else if (w_wait_last) w_err[3] = 1'b1;
          else                  w_wait_cnt_nxt = r_wait_cnt + TW'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_wait_cnt   <= '0;
      r_adr        <= '0;
      r_we         <= 1'b0;
      r_sel        <= '0;
      r_dat        <= '0;
      r_err_pulse  <= 1'b0;
      r_err_flags  <= '0;
      r_first_code <= '0;
      r_first_adr  <= '0;
      r_err_cnt    <= '0;
      r_xfer_cnt   <= '0;
    end else begin
      r_wait_cnt <= w_wait_cnt_nxt;
      if (w_capture) begin
        r_adr <= wb_adr_i;
        r_we  <= wb_we_i;
        r_sel <= wb_sel_i;
        r_dat <= wb_dat_i;
      end
      if (clr_i) begin
        r_err_pulse  <= 1'b0;
        r_err_flags  <= '0;
        r_first_code <= '0;
        r_first_adr  <= '0;
        r_err_cnt    <= '0;
        r_xfer_cnt   <= '0;
      end else begin
        r_err_pulse <= |w_err;
        r_err_flags <= r_err_flags | w_err;
        if ((|w_err) && (r_err_cnt != {CW{1'b1}}))
          r_err_cnt <= r_err_cnt + CW'(1);
        if (w_xfer && (r_xfer_cnt != {CW{1'b1}}))
          r_xfer_cnt <= r_xfer_cnt + CW'(1);
        if ((|w_err) && (r_first_code == 3'd0)) begin
          r_first_code <= lowest_code(w_err);
          r_first_adr  <= wb_adr_i;
        end
      end
    end
  end

  assign busy_o           = (r_state != S_IDLE);
  assign err_pulse_o      = r_err_pulse;
  assign err_flags_o      = r_err_flags;
  assign first_err_code_o = r_first_code;
  assign first_err_adr_o  = r_first_adr;
  assign err_cnt_o        = r_err_cnt;
  assign xfer_cnt_o       = r_xfer_cnt;

endmodule
